paddsb_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the PADDSB (parallel saturating nibble add/sub) execute operation. It shares one 4-bit saturating add/sub unit across all nibbles of a 16-bit operand pair, processing one nibble per cycle, LSB nibble first. It has a valid/ready handshake toward decode/issue and toward writeback. It sits in the Execute stage as an area-reduced alternative to the fully parallel PADDSB datapath.

---
 rtl/paddsb_pkg.sv | 14 +
 rtl/paddsb_seq_ctrl_if.sv | 29 ++
 rtl/paddsb_seq_ctrl_sat_nib_addsub.sv | 27 ++
 rtl/paddsb_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_paddsb_seq_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/paddsb_pkg.sv
// Shared constants and types for the PADDSB nibble sequencer.
//   NIB_W / NUM_NIB : lane width and lane count (data width = NIB_W*NUM_NIB)
//   SAT_POS/SAT_NEG : saturation limits of a signed lane
//   paddsb_state_t  : sequencer FSM states
package paddsb_pkg;
  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;
  localparam int DATA_W  = NIB_W * NUM_NIB;
  localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [NIB_W-1:0] SAT_POS = 4'h7;
  localparam logic [NIB_W-1:0] SAT_NEG = 4'h8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} paddsb_state_t;
endpackage

// File: rtl/paddsb_seq_ctrl_if.sv
// Request/response bundle for paddsb_seq_ctrl.
//   in_valid/in_ready : request handshake carrying A, B, sub
//   out_valid/out_ready: result handshake carrying Sum (and sat_flags when
//                        PADDSB_SAT_FLAGS_EN is defined)
// master = requester/consumer side, slave = the sequencer.
interface paddsb_seq_ctrl_if;
  import paddsb_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] Sum;
`ifdef PADDSB_SAT_FLAGS_EN
  logic [NUM_NIB-1:0] sat_flags;

  modport master (output in_valid, A, B, sub, out_ready,
                  input  in_ready, out_valid, Sum, sat_flags);
  modport slave  (input  in_valid, A, B, sub, out_ready,
                  output in_ready, out_valid, Sum, sat_flags);
`else
  modport master (output in_valid, A, B, sub, out_ready,
                  input  in_ready, out_valid, Sum);
  modport slave  (input  in_valid, A, B, sub, out_ready,
                  output in_ready, out_valid, Sum);
`endif
endinterface

// File: rtl/paddsb_seq_ctrl_sat_nib_addsub.sv
// sat_nib_addsub: combinational signed saturating add/sub of one lane.
//   a, b : lane operands (two's complement)
//   sub  : 0 = a+b, 1 = a-b
//   r    : saturated result
//   sat  : high when the lane overflowed and was clamped
module sat_nib_addsub
  import paddsb_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             sub,
  output logic [NIB_W-1:0] r,
  output logic             sat
);
  localparam int MSB = NIB_W - 1;

  logic [NIB_W-1:0] raw;

  always_comb begin
    raw = sub ? (a - b) : (a + b);
    // add overflows when operand signs agree; sub when they differ;
    // either way the result sign departs from a's sign
    if (sub) sat = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
    else     sat = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
    r = sat ? (a[MSB] ? SAT_NEG : SAT_POS) : raw;
  end
endmodule

// File: rtl/paddsb_seq_ctrl.sv
// paddsb_seq_ctrl: multi-cycle PADDSB sequencer. One shared lane unit
// processes one nibble per cycle, LSB lane first.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : paddsb_seq_ctrl_if.slave (request in, result out)
// Optional macro PADDSB_SAT_FLAGS_EN adds per-lane saturation flags.
// Flow: IDLE (accept) -> RUN x NUM_NIB -> DONE (hold until out_ready).
module paddsb_seq_ctrl
  import paddsb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  paddsb_seq_ctrl_if.slave  bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  paddsb_state_t     state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [DATA_W-1:0] a_q,     a_d;
  logic [DATA_W-1:0] b_q,     b_d;
  logic              sub_q,   sub_d;
  logic [DATA_W-1:0] res_q,   res_d;  // working lanes, filled during RUN
  logic [DATA_W-1:0] sum_q,   sum_d;  // last completed result (drives Sum)
`ifdef PADDSB_SAT_FLAGS_EN
  logic [NUM_NIB-1:0] flags_q, flags_d;
`endif

  logic [NIB_W-1:0] lane_a, lane_b, lane_r;
  logic             lane_sat;

  assign lane_a = a_q[idx_q*NIB_W +: NIB_W];
  assign lane_b = b_q[idx_q*NIB_W +: NIB_W];

  sat_nib_addsub u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .sub (sub_q),
    .r   (lane_r),
    .sat (lane_sat)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    sum_d   = sum_q;
`ifdef PADDSB_SAT_FLAGS_EN
    flags_d = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sub_d   = bus.sub;
          res_d   = '0;
          idx_d   = '0;
`ifdef PADDSB_SAT_FLAGS_EN
          flags_d = '0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q*NIB_W +: NIB_W] = lane_r;
`ifdef PADDSB_SAT_FLAGS_EN
        flags_d[idx_q] = lane_sat;
`endif
        if (idx_q == LAST_IDX) begin
          // publish the full word only once all lanes are in, so Sum
          // never shows a partially built result
          sum_d   = res_d;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
`ifdef PADDSB_SAT_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
`ifdef PADDSB_SAT_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Sum       = sum_q;
`ifdef PADDSB_SAT_FLAGS_EN
  assign bus.sat_flags = flags_q;
`endif

  // lane_sat only feeds the optional flags
  logic unused_sat;
  assign unused_sat = lane_sat;
endmodule

// File: tb/tb_paddsb_seq_ctrl.sv
// Self-checking bench for paddsb_seq_ctrl: reset state, table of directed
// vectors, backpressure, reset mid-op and back-to-back random ops.
module tb_paddsb_seq_ctrl;
  import paddsb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  paddsb_seq_ctrl_if ifc ();

  paddsb_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  flg;
  } exp_t;

  typedef struct {
    string       nm;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] sum;
    logic [3:0]  flg;
  } vec_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference: widen to int, clamp to the signed nibble range.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    e.sum = '0;
    e.flg = '0;
    for (int i = 0; i < 4; i++) begin
      logic signed [3:0] xa, xb;
      int r;
      logic [3:0] rl;
      xa = a[i*4 +: 4];
      xb = b[i*4 +: 4];
      r = s ? (int'(xa) - int'(xb)) : (int'(xa) + int'(xb));
      if (r > 7)       begin r = 7;  e.flg[i] = 1'b1; end
      else if (r < -8) begin r = -8; e.flg[i] = 1'b1; end
      rl = r[3:0];
      e.sum[i*4 +: 4] = rl;
    end
    return e;
  endfunction

  task automatic pop_chk(input string nm);
    exp_t e;
    if (q.size() == 0) begin
      chk({nm, "_unexpected_result"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({nm, "_sum"}, {16'h0, ifc.Sum}, {16'h0, e.sum});
`ifdef PADDSB_SAT_FLAGS_EN
      chk({nm, "_flags"}, {28'h0, ifc.sat_flags}, {28'h0, e.flg});
`endif
    end
  endtask

  // Present a request and push its expectation; returns at the negedge
  // following the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, input exp_t e);
    int k = 0;
    @(negedge clk);
    while (!ifc.in_ready && k < 20) begin @(negedge clk); k++; end
    if (!ifc.in_ready) chk("send_timeout", 32'd0, 32'd1);
    ifc.in_valid = 1'b1;
    ifc.A = a;
    ifc.B = b;
    ifc.sub = s;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.A = $urandom;
    ifc.B = $urandom;
  endtask

  // Wait for out_valid; lat counts edges from the accepting edge (=1).
  task automatic wait_out(output int lat);
    lat = 1;
    while (!ifc.out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!ifc.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vec_t vt[7];
    int   lat;
    int   cyc, prev, got, sent;
    logic [15:0] ra, rb;
    logic rs;

    vt[0] = '{"add_basic",  16'h1234, 16'h1111, 1'b0, 16'h2345, 4'b0000};
    vt[1] = '{"add_satpos", 16'h7777, 16'h1111, 1'b0, 16'h7777, 4'b1111};
    vt[2] = '{"add_satneg", 16'h8888, 16'h8888, 1'b0, 16'h8888, 4'b1111};
    vt[3] = '{"add_mixed",  16'h7034, 16'h1011, 1'b0, 16'h7045, 4'b1000};
    vt[4] = '{"sub_basic",  16'h4444, 16'h1111, 1'b1, 16'h3333, 4'b0000};
    vt[5] = '{"sub_satpos", 16'h7777, 16'h8888, 1'b1, 16'h7777, 4'b1111};
    vt[6] = '{"sub_satneg", 16'h8888, 16'h7777, 1'b1, 16'h8888, 4'b1111};

    ifc.in_valid = 1'b0;
    ifc.A = '0;
    ifc.B = '0;
    ifc.sub = 1'b0;
    ifc.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'h0, ifc.in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, ifc.out_valid}, 32'd0);
    chk("rst_sum", {16'h0, ifc.Sum}, 32'h0);
`ifdef PADDSB_SAT_FLAGS_EN
    chk("rst_flags", {28'h0, ifc.sat_flags}, 32'h0);
`endif
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 7; i++) begin
      send(vt[i].a, vt[i].b, vt[i].s, '{vt[i].sum, vt[i].flg});
      wait_out(lat);
      chk({vt[i].nm, "_latency"}, lat, NUM_NIB + 1);
      pop_chk(vt[i].nm);
      @(negedge clk);
      chk({vt[i].nm, "_in_ready_after"}, {31'h0, ifc.in_ready}, 32'd1);
      chk({vt[i].nm, "_out_valid_drop"}, {31'h0, ifc.out_valid}, 32'd0);
    end

    // backpressure: result held, new request ignored
    ifc.out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, '{16'h2345, 4'b0000});
    wait_out(lat);
    ifc.in_valid = 1'b1;
    ifc.A = 16'hFFFF;
    ifc.B = 16'hFFFF;
    ifc.sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_sum", {16'h0, ifc.Sum}, 32'h2345);
      chk("bp_out_valid", {31'h0, ifc.out_valid}, 32'd1);
      chk("bp_in_ready", {31'h0, ifc.in_ready}, 32'd0);
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    pop_chk("bp");
    @(negedge clk);
    chk("bp_in_ready_after", {31'h0, ifc.in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'h0, ifc.out_valid}, 32'd0);
    @(negedge clk);
    chk("bp_second_not_taken", {31'h0, ifc.in_ready}, 32'd1);

    // reset in the second RUN cycle
    send(16'h7777, 16'h1111, 1'b0, '{16'h7777, 4'b1111});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", {31'h0, ifc.out_valid}, 32'd0);
    chk("rstmid_in_ready", {31'h0, ifc.in_ready}, 32'd1);
    chk("rstmid_sum", {16'h0, ifc.Sum}, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h1234, 16'h1111, 1'b0, '{16'h2345, 4'b0000});
    wait_out(lat);
    chk("after_rst_latency", lat, NUM_NIB + 1);
    pop_chk("after_rst");

    // back-to-back random ops, in_valid held whenever idle
    cyc = 0; prev = -1; got = 0; sent = 0;
    ifc.out_ready = 1'b1;
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ifc.out_valid) begin
        pop_chk("b2b");
        if (prev >= 0) chk("b2b_spacing", cyc - prev, NUM_NIB + 2);
        prev = cyc;
        got++;
      end
      if (ifc.in_ready && sent < 10) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        ifc.in_valid = 1'b1;
        ifc.A = ra;
        ifc.B = rb;
        ifc.sub = rs;
        q.push_back(model(ra, rb, rs));
        sent++;
      end else begin
        ifc.in_valid = 1'b0;
      end
    end
    if (got < 10) chk("b2b_timeout", got, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
